avalon_wait_bridge: RTL
=======================

Name: avalon_wait_bridge

Overview:
- Avalon-MM pipeline stage between top_level_cpu's bus master and the RAM slave.
- Registers each CPU request and holds it stable on the slave side.
- Inserts a configurable number of wait states so CPU stall handling is stressed in every ALU/memory testcase.
- Captures read data and reports protocol errors and slave timeouts.

Parameters:
- WAIT_CYCLES, 2, extra wait states inserted before the slave access (0..255).
- TIMEOUT, 64, cycles the slave may hold s_waitrequest before the access is aborted (1..65535).
- ABORT_DATA, 32'hDEADBEEF, value returned on m_readdata for an aborted read.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- m_address  input  32  CPU byte address.
- m_read  input  1  CPU read strobe.
- m_write  input  1  CPU write strobe.
- m_writedata  input  32  CPU write data.
- m_byteenable  input  4  CPU byte lanes.
- m_waitrequest  output  1  stall to CPU.
- m_readdata  output  32  read data to CPU.
- s_address  output  32  latched address to RAM.
- s_read  output  1  read strobe to RAM.
- s_write  output  1  write strobe to RAM.
- s_writedata  output  32  latched write data.
- s_byteenable  output  4  latched byte lanes.
- s_waitrequest  input  1  RAM stall.
- s_readdata  input  32  RAM read data.
- rd_count  output  16  completed reads, wraps 16'hFFFF->0.
- wr_count  output  16  completed writes, wraps.
- proto_err  output  1  sticky protocol-error flag.
- timeout_err  output  1  sticky timeout flag.

Behaviour:
- Reset, asynchronous, effective immediately, including mid-transaction:
  - state=IDLE.
  - s_read, s_write, proto_err, timeout_err = 0.
  - s_address, s_writedata, m_readdata = 0; s_byteenable = 0.
  - counters = 0.
- m_waitrequest is combinational: 1 when (m_read|m_write) is high and state!=DONE, else 0. During reset it follows the same equation with state=IDLE.
- States:
  - IDLE: on a clock edge with m_read^m_write, latch address/data/byteenable/type. Go to WAIT if WAIT_CYCLES>0, else ISSUE.
  - WAIT: down-counter loaded with WAIT_CYCLES-1. Go to ISSUE when it reaches 0.
  - ISSUE: drive s_read or s_write from the latched copy. The slave samples the access on the edge where s_waitrequest=0. On that edge capture s_readdata into m_readdata (reads only) and go to DONE. If s_waitrequest stays high for TIMEOUT consecutive cycles, drop the strobes, set timeout_err, load m_readdata=ABORT_DATA (reads), and go to DONE.
  - DONE: exactly one cycle with m_waitrequest=0. Increment rd_count or wr_count (aborted accesses are counted too). Go to IDLE.
- Latency with a zero-wait slave: request first sampled at cycle 0, m_waitrequest low in cycle WAIT_CYCLES+2. Each slave stall cycle adds one.
- Back-to-back requests: a request held high through DONE is completed once. The next request is latched at the first IDLE edge after DONE, so there is no bubble beyond IDLE.
- m_read&m_write together in IDLE: set proto_err, no slave access, go directly to DONE, m_readdata=0, no counter increment.
- In WAIT/ISSUE, if any master request signal differs from its latched copy, set proto_err. The slave access continues using the latched values.
- m_readdata holds its last captured value between transactions. Write completions do not modify it.
- The slave strobes are never asserted outside ISSUE.

Decomposition:
- Package avalon_bridge_pkg holds:
  - state enum {IDLE, WAIT, ISSUE, DONE};
  - txn_type enum {RD, WR};
  - constant ABORT_DATA_DEFAULT=32'hDEADBEEF;
  - localparam width of the wait counter (8) and timeout counter (16).
- One sub-module: bridge_down_counter, a load/decrement/zero-flag counter instantiated twice, once for the wait count and once for the timeout.

Test Plan:
- WAIT_CYCLES=2, zero-wait RAM, CPU read of 0x0000_0004 holding 0x24032468 -> m_waitrequest high cycles 0-3, low cycle 4, m_readdata=0x24032468, rd_count=1.
- WAIT_CYCLES=0, write 0x0000_2468 to 0x0000_0010 with byteenable 4'b0011, then read back -> write completes cycle 2, readback returns 0x0000_2468, wr_count=1, rd_count=1.
- RAM holds s_waitrequest high for 5 cycles in ISSUE -> completion delayed by exactly 5 cycles, s_address stable throughout, no error flags.
- TIMEOUT=8, RAM stalls forever on a read -> s_read drops after 8 ISSUE cycles, timeout_err=1, m_readdata=0xDEADBEEF, rd_count increments.
- m_read and m_write both high in IDLE -> proto_err=1, s_read/s_write never asserted, completion in cycle 1, counters unchanged. Separately, changing m_address during WAIT sets proto_err while the RAM still sees the original address.
- Assert reset during WAIT of a read -> s_read stays 0, state IDLE, counters 0. After release the same held request completes normally with full latency.

Source files
------------

// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Avalon-MM wait-state bridge.
// State encodings are plain constants so legacy tooling can consume them.
package avalon_bridge_pkg;

    localparam int WAIT_CNT_W    = 8;
    localparam int TIMEOUT_CNT_W = 16;

    localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef enum logic {
        TXN_RD = 1'b0,
        TXN_WR = 1'b1
    } txn_type_t;

endpackage

// File: rtl/bridge_down_counter.sv
// Loadable down-counter with a terminal-count flag; load has priority over decrement.
// Decrementing saturates at zero so a stray dec can never wrap the count.
module bridge_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/avalon_wait_bridge.sv
// Avalon-MM pipeline stage: latches each CPU request, adds WAIT_CYCLES wait states,
// then drives the slave from the latched copy with a stall timeout and sticky error flags.
module avalon_wait_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] ABORT_DATA  = ABORT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_address,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [31:0] m_writedata,
    input  logic [3:0]  m_byteenable,
    output logic        m_waitrequest,
    output logic [31:0] m_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err,
    output logic        timeout_err
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LOAD =
        TIMEOUT_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t    state;
    state_t    state_next;
    txn_type_t lat_type;
    logic      skip_count;

    logic req_one;
    logic req_both;
    logic req_changed;
    logic wait_load;
    logic wait_dec;
    logic wait_zero;
    logic to_load;
    logic to_dec;
    logic to_zero;
    logic issue_ok;
    logic issue_abort;

    assign req_one  = m_read ^ m_write;
    assign req_both = m_read & m_write;

    assign m_waitrequest = (m_read | m_write) && (state != ST_DONE);

    // Slave strobes are decoded from state so they can never leak outside ISSUE.
    assign s_read  = (state == ST_ISSUE) && (lat_type == TXN_RD);
    assign s_write = (state == ST_ISSUE) && (lat_type == TXN_WR);

    assign req_changed = (m_address    != s_address)
                      || (m_writedata  != s_writedata)
                      || (m_byteenable != s_byteenable)
                      || (m_read  != (lat_type == TXN_RD))
                      || (m_write != (lat_type == TXN_WR));

    assign wait_load = (state == ST_IDLE) && req_one && HAS_WAIT;
    assign wait_dec  = (state == ST_WAIT) && !wait_zero;

    assign to_load = ((state == ST_IDLE) && req_one && !HAS_WAIT)
                  || ((state == ST_WAIT) && wait_zero);
    assign to_dec  = (state == ST_ISSUE) && s_waitrequest && !to_zero;

    assign issue_ok    = (state == ST_ISSUE) && !s_waitrequest;
    assign issue_abort = (state == ST_ISSUE) && s_waitrequest && to_zero;

    bridge_down_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (wait_load),
        .load_value (WAIT_LOAD),
        .dec        (wait_dec),
        .zero       (wait_zero)
    );

    bridge_down_counter #(
        .WIDTH (TIMEOUT_CNT_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .load_value (TIMEOUT_LOAD),
        .dec        (to_dec),
        .zero       (to_zero)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_both) begin
                    state_next = ST_DONE;
                end else if (req_one) begin
                    state_next = HAS_WAIT ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (wait_zero) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ok || issue_abort) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat_type     <= TXN_RD;
            skip_count   <= 1'b0;
            s_address    <= '0;
            s_writedata  <= '0;
            s_byteenable <= '0;
            m_readdata   <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            proto_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_next;

            if ((state == ST_IDLE) && req_one) begin
                s_address    <= m_address;
                s_writedata  <= m_writedata;
                s_byteenable <= m_byteenable;
                lat_type     <= m_read ? TXN_RD : TXN_WR;
                skip_count   <= 1'b0;
            end

            // Simultaneous read and write is rejected without touching the slave.
            if ((state == ST_IDLE) && req_both) begin
                proto_err  <= 1'b1;
                m_readdata <= '0;
                skip_count <= 1'b1;
            end

            if (((state == ST_WAIT) || (state == ST_ISSUE)) && req_changed) begin
                proto_err <= 1'b1;
            end

            if (issue_ok && (lat_type == TXN_RD)) begin
                m_readdata <= s_readdata;
            end

            if (issue_abort) begin
                timeout_err <= 1'b1;
                if (lat_type == TXN_RD) begin
                    m_readdata <= ABORT_DATA;
                end
            end

            // Aborted accesses still count; only rejected requests do not.
            if ((state == ST_DONE) && !skip_count) begin
                if (lat_type == TXN_RD) begin
                    rd_count <= rd_count + 16'd1;
                end else begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

endmodule
